// File: rtl/stopwatch_up.sv
// stopwatch_up: count-up MM:SS BCD stopwatch that stops at a loaded target minute.
// Optional lap-hold display registers are built when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_up #(
  parameter int CLK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] tgt_min10,
  input  logic [3:0] tgt_min1,
  input  logic       lap,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       done,
  output logic       ErrorLED
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0] s0_q, s0_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] m0_q, m0_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] tgt10_q, tgt10_d;
  logic [3:0] tgt1_q, tgt1_d;
  logic chk_q, chk_d;
  logic running_q, done_q;
  logic err, tick, hit, held;

  always_comb begin
    err = (tgt10_q > 4'd9) || (tgt1_q > 4'd9);
    tick = (state_q == RUN) && (presc_q == PMAX);
    held = (state_q == IDLE) || (state_q == PAUSE);
    // completion is judged on the count a tick produced one cycle earlier
    hit = chk_q
       && ((state_q == RUN) || (state_q == PAUSE))
       && ({tgt10_q, tgt1_q} != 8'h00)
       && (m1_q == tgt10_q) && (m0_q == tgt1_q)
       && (s1_q == 4'd0) && (s0_q == 4'd0);

    state_d = state_q;
    presc_d = presc_q;
    s0_d = s0_q;
    s1_d = s1_q;
    m0_d = m0_q;
    m1_d = m1_q;
    tgt10_d = tgt10_q;
    tgt1_d = tgt1_q;
    chk_d = tick;

    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (s0_q == 4'd9) begin
        s0_d = 4'd0;
        if (s1_q == 4'd5) begin
          s1_d = 4'd0;
          if (m0_q == 4'd9) begin
            m0_d = 4'd0;
            m1_d = (m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1;
          end else begin
            m0_d = m0_q + 4'd1;
          end
        end else begin
          s1_d = s1_q + 4'd1;
        end
      end else begin
        s0_d = s0_q + 4'd1;
      end
    end

    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      s0_d = 4'd0;
      s1_d = 4'd0;
      m0_d = 4'd0;
      m1_d = 4'd0;
      chk_d = 1'b0;
    end else if (hit) begin
      state_d = DONE;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (start && !err && held) begin
      if (state_q == IDLE) begin
        presc_d = '0;
      end
      state_d = RUN;
    end else if (load && held) begin
      tgt10_d = tgt_min10;
      tgt1_d = tgt_min1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      s0_q <= 4'd0;
      s1_q <= 4'd0;
      m0_q <= 4'd0;
      m1_q <= 4'd0;
      tgt10_q <= 4'd0;
      tgt1_q <= 4'd0;
      chk_q <= 1'b0;
      running_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      m0_q <= m0_d;
      m1_q <= m1_d;
      tgt10_q <= tgt10_d;
      tgt1_q <= tgt1_d;
      chk_q <= chk_d;
      running_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
    end
  end

  assign running = running_q;
  assign done = done_q;
  assign ErrorLED = err;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_prev_q;
  logic show_q, show_d;
  logic cap;
  logic [3:0] l0_q, l1_q, l2_q, l3_q;

  always_comb begin
    cap = lap && !lap_prev_q && (state_q == RUN);
    show_d = !clear && lap && (show_q || cap);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_prev_q <= 1'b0;
      show_q <= 1'b0;
      l0_q <= 4'd0;
      l1_q <= 4'd0;
      l2_q <= 4'd0;
      l3_q <= 4'd0;
    end else begin
      lap_prev_q <= lap;
      show_q <= show_d;
      if (clear) begin
        l0_q <= 4'd0;
        l1_q <= 4'd0;
        l2_q <= 4'd0;
        l3_q <= 4'd0;
      end else if (cap) begin
        l0_q <= s0_q;
        l1_q <= s1_q;
        l2_q <= m0_q;
        l3_q <= m1_q;
      end
    end
  end

  assign d0 = show_q ? l0_q : s0_q;
  assign d1 = show_q ? l1_q : s1_q;
  assign d2 = show_q ? l2_q : m0_q;
  assign d3 = show_q ? l3_q : m1_q;
`else
  logic lap_unused;
  assign lap_unused = lap;

  assign d0 = s0_q;
  assign d1 = s1_q;
  assign d2 = m0_q;
  assign d3 = m1_q;
`endif

endmodule

// File: tb/tb_stopwatch_up.sv
// tb_stopwatch_up: randomized and directed bench for stopwatch_up.
// A seconds-level reference model feeds a per-cycle expectation queue.
module tb_stopwatch_up;

  localparam int DIV = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;
  logic load = 1'b0;
  logic [3:0] tgt_min10 = 4'd0;
  logic [3:0] tgt_min1 = 4'd0;
  logic lap = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic running, done, ErrorLED;

  stopwatch_up #(.CLK_DIV(DIV)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .clear(clear),
    .load(load),
    .tgt_min10(tgt_min10),
    .tgt_min1(tgt_min1),
    .lap(lap),
    .d0(d0),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .running(running),
    .done(done),
    .ErrorLED(ErrorLED)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    logic [15:0] dig;
    logic run;
    logic dn;
    logic err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int phase = 0;

  // reference model: whole seconds since 00:00 plus a plain state code
  int m_st = S_IDLE;
  int m_secs = 0;
  int m_presc = 0;
  int m_t10 = 0;
  int m_t1 = 0;
  int m_lapv = 0;
  bit m_chk = 0;
  bit m_show = 0;
  bit m_lprev = 0;

  function automatic logic [15:0] to_dig(input int s);
    logic [15:0] r;
    r[15:12] = 4'(s / 600);
    r[11:8] = 4'((s / 60) % 10);
    r[7:4] = 4'((s % 60) / 10);
    r[3:0] = 4'(s % 10);
    return r;
  endfunction

  task automatic model_step();
    int ns, nsecs, np, tgt;
    bit tick, hit, err, nchk, cap;
    exp_t e;
    if (reset) begin
      m_st = S_IDLE;
      m_secs = 0;
      m_presc = 0;
      m_t10 = 0;
      m_t1 = 0;
      m_lapv = 0;
      m_chk = 0;
      m_show = 0;
      m_lprev = 0;
    end else begin
      err = (m_t10 > 9) || (m_t1 > 9);
      tick = (m_st == S_RUN) && (m_presc == DIV - 1);
      ns = m_st;
      nsecs = m_secs;
      np = m_presc;
      nchk = tick;
      if (m_st == S_RUN) begin
        np = tick ? 0 : m_presc + 1;
        if (tick) nsecs = (m_secs + 1) % 6000;
      end
      tgt = m_t10 * 10 + m_t1;
      hit = m_chk && (m_st == S_RUN || m_st == S_PAUSE) && !err
         && tgt != 0 && m_secs == tgt * 60;
      cap = lap && !m_lprev && (m_st == S_RUN);
      if (clear) begin
        ns = S_IDLE;
        nsecs = 0;
        np = 0;
        nchk = 0;
      end else if (hit) begin
        ns = S_DONE;
      end else if (stop) begin
        if (m_st == S_RUN) ns = S_PAUSE;
      end else if (start && !err && (m_st == S_IDLE || m_st == S_PAUSE)) begin
        if (m_st == S_IDLE) np = 0;
        ns = S_RUN;
      end else if (load && (m_st == S_IDLE || m_st == S_PAUSE)) begin
        m_t10 = int'(tgt_min10);
        m_t1 = int'(tgt_min1);
      end
      if (clear) m_lapv = 0;
      else if (cap) m_lapv = m_secs;
      m_show = !clear && lap && (m_show || cap);
      m_lprev = lap;
      m_st = ns;
      m_secs = nsecs;
      m_presc = np;
      m_chk = nchk;
    end
    e.ph = phase;
`ifdef STOPWATCH_LAP_HOLD_EN
    e.dig = to_dig(m_show ? m_lapv : m_secs);
`else
    e.dig = to_dig(m_secs);
`endif
    e.run = (m_st == S_RUN);
    e.dn = (m_st == S_DONE);
    e.err = (m_t10 > 9) || (m_t1 > 9);
    sb.push_back(e);
  endtask

  // called just after a negedge (or at time 0): inputs are stable for the next posedge
  task automatic go(input int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic chk_dig(input string nm, input logic [15:0] want);
    logic [15:0] got;
    got = {d3, d2, d1, d0};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %04h want %04h", nm, got, want);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [15:0] gd;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        gd = {d3, d2, d1, d0};
        total++;
        if (gd !== e.dig || running !== e.run || done !== e.dn
            || ErrorLED !== e.err) begin
          bad++;
          $display("FAIL sb ph%0d: got d=%04h run=%0b done=%0b err=%0b want d=%04h run=%0b done=%0b err=%0b",
                   e.ph, gd, running, done, ErrorLED, e.dig, e.run, e.dn, e.err);
        end
      end
    end
  end

  initial begin : driver
    phase = 1;
    reset = 1'b1;
    go(2);
    chk_dig("reset_digits", 16'h0000);
    chk_bit("reset_running", running, 1'b0);
    chk_bit("reset_err", ErrorLED, 1'b0);
    reset = 1'b0;
    load = 1'b1;
    tgt_min10 = 4'd0;
    tgt_min1 = 4'd1;
    go(1);
    load = 1'b0;
    start = 1'b1;
    go(1);
    start = 1'b0;
    go(250);
    chk_dig("done_digits", 16'h0100);
    chk_bit("done_flag", done, 1'b1);
    chk_bit("done_running", running, 1'b0);

    phase = 2;
    clear = 1'b1;
    go(1);
    clear = 1'b0;
    start = 1'b1;
    go(1);
    start = 1'b0;
    go(29);
    stop = 1'b1;
    go(10);
    chk_dig("pause_hold", 16'h0007);
    chk_bit("pause_running", running, 1'b0);
    stop = 1'b0;
    start = 1'b1;
    go(1);
    start = 1'b0;
    go(20);

    phase = 3;
    clear = 1'b1;
    go(1);
    clear = 1'b0;
    load = 1'b1;
    tgt_min10 = 4'd0;
    tgt_min1 = 4'hA;
    go(1);
    load = 1'b0;
    chk_bit("err_set", ErrorLED, 1'b1);
    start = 1'b1;
    go(20);
    chk_bit("err_blocks_run", running, 1'b0);
    chk_dig("err_digits", 16'h0000);
    start = 1'b0;
    load = 1'b1;
    tgt_min1 = 4'd0;
    go(1);
    load = 1'b0;
    chk_bit("err_cleared", ErrorLED, 1'b0);

    phase = 4;
    start = 1'b1;
    go(1);
    start = 1'b0;
    go(23999);
    chk_dig("wrap_pre", 16'h9959);
    go(1);
    chk_dig("wrap_post", 16'h0000);
    chk_bit("wrap_running", running, 1'b1);
    chk_bit("wrap_done", done, 1'b0);

    phase = 5;
    clear = 1'b1;
    go(1);
    clear = 1'b0;
    load = 1'b1;
    tgt_min1 = 4'd1;
    go(1);
    load = 1'b0;
    start = 1'b1;
    go(1);
    start = 1'b0;
    go(39);
    chk_dig("pre_clear", 16'h0009);
    clear = 1'b1;
    go(1);
    clear = 1'b0;
    chk_dig("clear_tick", 16'h0000);
    chk_bit("clear_running", running, 1'b0);
    start = 1'b1;
    go(1);
    start = 1'b0;
    go(250);
    chk_bit("target_kept", done, 1'b1);
    chk_dig("target_kept_dig", 16'h0100);

    phase = 6;
    clear = 1'b1;
    go(1);
    clear = 1'b0;
    start = 1'b1;
    go(1);
    start = 1'b0;
    go(12);
    lap = 1'b1;
    go(12);
`ifdef STOPWATCH_LAP_HOLD_EN
    chk_dig("lap_hold", 16'h0003);
`else
    chk_dig("lap_ignored", 16'h0006);
`endif
    lap = 1'b0;
    go(1);
    chk_dig("lap_release", 16'h0006);

    phase = 7;
    clear = 1'b1;
    go(1);
    clear = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 1499) == 0);
      clear = ($urandom_range(0, 399) == 0);
      stop = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 7) == 0);
      load = ($urandom_range(0, 19) == 0);
      tgt_min10 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 1));
      tgt_min1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) lap = ~lap;
      go(1);
    end
    reset = 1'b0;
    clear = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    load = 1'b0;
    lap = 1'b0;

    @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_up.md
Name: stopwatch_up

Overview:
- Count-up MM:SS stopwatch in BCD. It is the counterpart to the countdown timer: it counts from 00:00 toward a switch-loaded target minute value and flags completion.
- It drives the same four-digit 7-segment display path (digit outputs d3..d0) and an LED.
- Its own prescaler turns the board clock into 1 s ticks.

Parameters:
- CLK_DIV, 100000000: board clocks per one-second tick. Legal range is 2 and up; benches use 4.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: level. Begin or resume counting.
- stop, input, 1: level. Pause counting.
- clear, input, 1: level. Zero the count and return to IDLE.
- load, input, 1: level. Capture the target minutes.
- tgt_min10, input, 4: target tens-of-minutes (BCD).
- tgt_min1, input, 4: target minutes (BCD).
- lap, input, 1: level. Freeze the display (used only with the optional feature).
- d0, output, 4: seconds units.
- d1, output, 4: seconds tens.
- d2, output, 4: minutes units.
- d3, output, 4: minutes tens.
- running, output, 1: high in RUN.
- done, output, 1: target reached.
- ErrorLED, output, 1: registered target is not valid BCD.

Behaviour:
- Reset (sync, active-high) and clear both set: state=IDLE, count=00:00, prescaler=0, target=00, running=0, done=0, ErrorLED=0 (after reset).
  - clear does NOT reset the target register.
- Control priority, highest first: reset > clear > stop > start > load.
- States and transitions:
  - IDLE: load captures the target. start and !ErrorLED go to RUN with prescaler=0.
  - RUN: stop goes to PAUSE. A tick advances the count.
  - PAUSE: count and prescaler hold their values. start goes to RUN and the prescaler resumes from its held value. load is accepted.
  - DONE: count holds and done=1. Only clear or reset leave DONE, both to IDLE.
- Target register: updates on the clock edge where load=1 in IDLE or PAUSE. load is ignored in RUN and DONE.
- ErrorLED = (tgt10_reg > 9) OR (tgt1_reg > 9). It is registered-derived and valid 1 cycle after load.
  - While ErrorLED=1, start is ignored.
  - If ErrorLED is set while in PAUSE, RUN stays blocked.
- Prescaler: counts 0..CLK_DIV-1 only in RUN. tick=1 for one cycle when prescaler==CLK_DIV-1, then the prescaler wraps to 0.
  - First tick comes CLK_DIV cycles after entering RUN from IDLE.
- Count rules on each tick:
  - d0 wraps 9→0 and carries.
  - d1 wraps 5→0 and carries.
  - d2 wraps 9→0 and carries.
  - d3 wraps 9→0.
  - All digits update in the same cycle.
- Completion:
  - Checked on the cycle after a tick updates the count.
  - If target≠00 and d3:d2 == target and d1:d0 == 00, go to DONE. running drops and done rises in that same cycle.
- Target 00 means free-run: 99:59 + tick → 00:00, no done, stays in RUN.
- A stop that coincides with a tick: the tick's count update is still committed, then the state goes to PAUSE.
- A clear that coincides with a tick: clear wins and the count is 00:00.
- Outputs: running and done are registered. d0..d3 come straight from the count registers (or the lap registers, see below).

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - In RUN, the rising edge of lap copies the count into lap registers. d0..d3 show the lap registers while lap=1, and the internal count keeps running.
  - When lap falls, the live count is displayed again on the next cycle.
  - DONE detection always uses the live count.
  - clear or reset zeroes the lap registers.
- Not defined: the lap port is ignored, d0..d3 always show the live count, and no lap registers are synthesized.

Test Plan (CLK_DIV=4):
- reset, load with tgt=0,1, start → ticks every 4 cycles; 00:59 → 01:00 then DONE; done=1, running=0, digits hold 01:00.
- Run to 00:07, hold stop 10 cycles, start → count stays 00:07 while paused; next tick arrives after the remaining prescaler cycles; no tick is lost or doubled.
- load tgt_min1=4'hA → ErrorLED=1 next cycle; start held 20 cycles → running stays 0 and digits stay 00:00.
- Target 00, preload by running to 99:59 (bench force or long run), one tick → 00:00, done=0, running=1.
- clear asserted in the same cycle as a tick at 00:09 → digits 00:00, state IDLE, target kept (done again at the old target after a restart).
- With STOPWATCH_LAP_HOLD_EN: lap rises at 00:03 and holds 12 cycles → display shows 00:03; on release the display shows 00:06.
